// File: rtl/tpu_seq_if.sv
// Job request and buffer/PE control bundle between a host and the TPU sequencer.
interface tpu_seq_if #(
  parameter int ARRAY  = 4,
  parameter int DIM_W  = 4,
  parameter int ADDR_W = 10
);
  localparam int RW = (ARRAY > 1) ? $clog2(ARRAY) : 1;

  logic              start;
  logic [DIM_W-1:0]  m, k, n;
  logic              a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              pe_clear;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_addr;
  logic [RW-1:0]     out_row_sel;
  logic [ARRAY-1:0]  out_byte_en;
  logic              busy, done;

  modport master (
    output start, m, k, n,
    input  a_rd_en, b_rd_en, a_addr, b_addr, pe_clear,
           out_wr_en, out_addr, out_row_sel, out_byte_en, busy, done
  );
  modport slave (
    input  start, m, k, n,
    output a_rd_en, b_rd_en, a_addr, b_addr, pe_clear,
           out_wr_en, out_addr, out_row_sel, out_byte_en, busy, done
  );
endinterface

// File: rtl/tpu_seq_ctrl.sv
// Tile sequencer for the systolic TPU: per output tile it clears the PEs, feeds
// k A/B words, drains the skew and writes the tile rows out; all outputs registered.
module tpu_seq_ctrl #(
  parameter int ARRAY  = 4,
  parameter int DIM_W  = 4,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
)(
  input logic     clk,
  input logic     rst,
  tpu_seq_if.slave bus
);
  localparam int DRAIN_N = RD_LAT + 2*ARRAY - 1;
  localparam int CNT_W   = $clog2(DRAIN_N + 1);
  localparam int RW      = (ARRAY > 1) ? $clog2(ARRAY) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_t;
  state_t state, state_n;

  logic              start_d, start_edge, job_zero;
  logic              feed_end, drain_end, tile_end, last_tile;
  logic [DIM_W-1:0]  m_l, k_l, n_l, mt, nt, kk;
  logic [CNT_W-1:0]  dcnt;
  logic [RW-1:0]     r;
  logic [ADDR_W-1:0] mt_num, nt_num, row, a_next, b_next, o_next;
  logic [ARRAY-1:0]  be_next;

  assign start_edge = bus.start & ~start_d;
  assign job_zero   = (bus.m == '0) | (bus.k == '0) | (bus.n == '0);

  assign mt_num = (ADDR_W'(m_l) + ADDR_W'(ARRAY-1)) / ADDR_W'(ARRAY);
  assign nt_num = (ADDR_W'(n_l) + ADDR_W'(ARRAY-1)) / ADDR_W'(ARRAY);
  assign row    = ADDR_W'(mt) * ADDR_W'(ARRAY) + ADDR_W'(r);
  assign a_next = ADDR_W'(mt) * ADDR_W'(k_l) + ADDR_W'(kk);
  assign b_next = ADDR_W'(nt) * ADDR_W'(k_l) + ADDR_W'(kk);
  assign o_next = row * nt_num + ADDR_W'(nt);

  assign feed_end  = (kk == k_l - 1'b1);
  assign drain_end = (dcnt == CNT_W'(DRAIN_N-1));
  assign tile_end  = (r == RW'(ARRAY-1));
  assign last_tile = (ADDR_W'(mt) == mt_num - 1'b1) && (ADDR_W'(nt) == nt_num - 1'b1);

  // Lane j carries column nt*ARRAY+j of C; lanes past n are masked.
  always_comb begin
    be_next = '0;
    for (int j = 0; j < ARRAY; j++)
      be_next[j] = (ADDR_W'(nt) * ADDR_W'(ARRAY) + ADDR_W'(j)) < ADDR_W'(n_l);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start_edge) state_n = job_zero ? DONE : CLEAR;
      CLEAR:      state_n = FEED;
      FEED:       if (feed_end)  state_n = DRAIN;
      DRAIN:      if (drain_end) state_n = WRITE;
      WRITE:      if (tile_end)  state_n = last_tile ? DONE : CLEAR;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d <= 1'b0;
      m_l <= '0; k_l <= '0; n_l <= '0;
      mt  <= '0; nt  <= '0; kk  <= '0;
      dcnt <= '0; r <= '0;
    end else begin
      start_d <= bus.start;
      case (state)
        IDLE, DONE: if (start_edge) begin
          m_l <= bus.m; k_l <= bus.k; n_l <= bus.n;
          mt  <= '0;    nt  <= '0;
        end
        CLEAR: begin kk <= '0; dcnt <= '0; r <= '0; end
        FEED:  kk   <= kk + 1'b1;
        DRAIN: dcnt <= dcnt + 1'b1;
        WRITE: begin
          r <= r + 1'b1;
          // nt is the inner tile loop
          if (tile_end) begin
            if (ADDR_W'(nt) == nt_num - 1'b1) begin
              nt <= '0;
              mt <= mt + 1'b1;
            end else begin
              nt <= nt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.a_rd_en     <= 1'b0; bus.b_rd_en <= 1'b0;
      bus.a_addr      <= '0;   bus.b_addr  <= '0;
      bus.pe_clear    <= 1'b0;
      bus.out_wr_en   <= 1'b0; bus.out_addr <= '0;
      bus.out_row_sel <= '0;   bus.out_byte_en <= '0;
      bus.busy        <= 1'b0; bus.done <= 1'b0;
    end else begin
      bus.pe_clear    <= (state == CLEAR);
      bus.a_rd_en     <= (state == FEED);
      bus.b_rd_en     <= (state == FEED);
      bus.a_addr      <= (state == FEED) ? a_next : '0;
      bus.b_addr      <= (state == FEED) ? b_next : '0;
      bus.out_wr_en   <= (state == WRITE) && (row < ADDR_W'(m_l));
      bus.out_addr    <= (state == WRITE) ? o_next : '0;
      bus.out_row_sel <= (state == WRITE) ? r : '0;
      bus.out_byte_en <= (state == WRITE) ? be_next : '0;
      bus.busy        <= (state_n != IDLE) && (state_n != DONE);
      bus.done        <= (state == DONE) && !start_edge;
    end
  end
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboarded bench for tpu_seq_ctrl: a reference tile walk queues the expected
// read/write beats, a per-cycle monitor pops and compares them.
module tb_tpu_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_seq_if bus ();
  tpu_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int m; int k; int n; int exp_done; int exp_wr;} vec_t;
  typedef struct {int a; int b;} rd_t;
  typedef struct {int addr; int row; int be;} wr_t;

  vec_t tbl[6];
  rd_t  rd_q[$];
  wr_t  wr_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc_rel, wr_cnt, clr_cnt, done_at;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference tile walk: mt outer, nt inner; k reads then ARRAY row writes.
  task automatic push_model(input int m, input int k, input int n);
    int mtn, ntn, row, be;
    if (m == 0 || k == 0 || n == 0) return;
    mtn = (m + 3) / 4;
    ntn = (n + 3) / 4;
    for (int mt = 0; mt < mtn; mt++)
      for (int nt = 0; nt < ntn; nt++) begin
        for (int kk = 0; kk < k; kk++) rd_q.push_back('{mt*k + kk, nt*k + kk});
        for (int r = 0; r < 4; r++) begin
          row = mt*4 + r;
          be  = 0;
          for (int j = 0; j < 4; j++) if (nt*4 + j < n) be |= (1 << j);
          if (row < m) wr_q.push_back('{row*ntn + nt, r, be});
        end
      end
  endtask

  task automatic tick();
    rd_t er;
    wr_t ew;
    @(negedge clk);
    cyc_rel++;
    if (bus.a_rd_en || bus.b_rd_en || bus.out_wr_en || bus.pe_clear)
      chk("strobe_excl",
          int'((bus.a_rd_en == bus.b_rd_en) && !(bus.a_rd_en && (bus.out_wr_en || bus.pe_clear))), 1);
    if (bus.pe_clear) clr_cnt++;
    if (bus.a_rd_en) begin
      if (rd_q.size() == 0) chk("rd_extra", 1, 0);
      else begin
        er = rd_q.pop_front();
        chk("a_addr", int'(bus.a_addr), er.a);
        chk("b_addr", int'(bus.b_addr), er.b);
      end
    end
    if (bus.out_wr_en) begin
      wr_cnt++;
      if (wr_q.size() == 0) chk("wr_extra", 1, 0);
      else begin
        ew = wr_q.pop_front();
        chk("out_addr", int'(bus.out_addr), ew.addr);
        chk("out_row_sel", int'(bus.out_row_sel), ew.row);
        chk("out_byte_en", int'(bus.out_byte_en), ew.be);
      end
    end
  endtask

  task automatic wait_done(input bit exp_busy, output int at);
    at = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (cyc_rel == 1) chk("busy_rise", int'(bus.busy), int'(exp_busy));
      if (bus.done) begin at = cyc_rel; break; end
    end
    if (at < 0) chk("done_timeout", 0, 1);
    else        chk("busy_at_done", int'(bus.busy), 0);
  endtask

  task automatic launch(input int m, input int k, input int n);
    bus.m = 4'(m); bus.k = 4'(k); bus.n = 4'(n);
    push_model(m, k, n);
    wr_cnt = 0; clr_cnt = 0; cyc_rel = 0;
    bus.start = 1'b1;
  endtask

  task automatic finish_job(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_done_sticky"}, int'(bus.done), 1);
    end
    bus.start = 1'b0;
    tick();
    chk({tag, "_rd_left"}, rd_q.size(), 0);
    chk({tag, "_wr_left"}, wr_q.size(), 0);
  endtask

  initial begin
    int nonzero;
    tbl[0] = '{4, 4, 4, 19, 4};
    tbl[1] = '{5, 3, 9, 98, 15};
    tbl[2] = '{4, 0, 4, 2, 0};
    tbl[3] = '{1, 1, 1, 16, 1};
    tbl[4] = '{7, 2, 5, 62, 14};
    tbl[5] = '{0, 3, 3, 2, 0};

    rst = 1'b1; bus.start = 1'b0; bus.m = '0; bus.k = '0; bus.n = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_strobes", int'({bus.a_rd_en, bus.b_rd_en, bus.pe_clear, bus.out_wr_en}), 0);
    chk("rst_addr", int'(bus.a_addr | bus.b_addr | bus.out_addr), 0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      nonzero = int'(tbl[i].m != 0 && tbl[i].k != 0 && tbl[i].n != 0);
      launch(tbl[i].m, tbl[i].k, tbl[i].n);
      wait_done(nonzero[0], done_at);
      chk($sformatf("v%0d_done_cycle", i), done_at, tbl[i].exp_done);
      chk($sformatf("v%0d_wr_count", i), wr_cnt, tbl[i].exp_wr);
      if (!nonzero[0]) chk($sformatf("v%0d_no_clear", i), clr_cnt, 0);
      finish_job($sformatf("v%0d", i));
    end

    // start re-toggled and m/k/n changed mid-FEED: job must be unaffected
    launch(3, 5, 3);
    repeat (4) tick();
    bus.start = 1'b0; bus.m = 4'd7; bus.k = 4'd7; bus.n = 4'd7;
    tick();
    bus.start = 1'b1;
    wait_done(1'b0, done_at);
    chk("toggle_done_cycle", done_at, 20);
    chk("toggle_wr_count", wr_cnt, 3);
    finish_job("toggle");
    launch(3, 5, 3);
    tick();
    chk("restart_clears_done", int'(bus.done), 0);
    wait_done(1'b0, done_at);
    chk("replay_done_cycle", done_at, 20);
    chk("replay_wr_count", wr_cnt, 3);
    finish_job("replay");

    // reset pulse mid-WRITE aborts the job immediately
    launch(4, 4, 4);
    for (int i = 0; i < 200 && !bus.out_wr_en; i++) tick();
    chk("reached_write", int'(bus.out_wr_en), 1);
    rst = 1'b1;
    #1;
    chk("abort_strobes", int'({bus.a_rd_en, bus.b_rd_en, bus.pe_clear, bus.out_wr_en}), 0);
    chk("abort_busy_done", int'({bus.busy, bus.done}), 0);
    chk("abort_out_addr", int'(bus.out_addr), 0);
    bus.start = 1'b0;
    rd_q.delete(); wr_q.delete();
    tick();
    rst = 1'b0;
    wr_cnt = 0;
    repeat (30) tick();
    chk("post_abort_writes", wr_cnt, 0);
    chk("post_abort_idle", int'(bus.busy), 0);
    launch(4, 4, 4);
    wait_done(1'b1, done_at);
    chk("clean_done_cycle", done_at, 19);
    chk("clean_wr_count", wr_cnt, 4);
    finish_job("clean");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
